uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the data-memory bus of the single-cycle RISC-V core (CPU_top). It consumes the core's store traffic.
- CPU stores to TXDATA push bytes into an internal FIFO. An 8N1 serializer drains the FIFO onto the tx pin at a programmable baud divisor.
- STATUS reads let firmware poll for space and completion without stalling the core.

Parameters:
- CLKS_PER_BIT, 868, reset value of the baud divisor (100 MHz / 115200).
- FIFO_DEPTH, 8, byte FIFO entries; power of two, ≥2.
- ADDR_W, 4, width of the peripheral-local byte address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- addr  in  ADDR_W  byte address within the peripheral; word-aligned.
- wdata  in  32  store data from the core.
- we  in  1  store strobe, valid for one cycle.
- re  in  1  load strobe.
- rdata  out  32  read data, combinational from addr; 0 when re=0.
- tx  out  1  serial output, idle high.
- irq  out  1  high while the FIFO is empty and the serializer is idle (TX done).

Behaviour:
- Register map:
  - 0x0 TXDATA (write-only): wdata[7:0] is pushed to the FIFO; reads return 0.
  - 0x4 STATUS (read): bit0 busy (serializer not IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky); all other bits 0. Writing 1 to bit3 clears overflow; other write bits are ignored.
  - 0x8 BAUD_DIV (R/W): bits[15:0] are the divisor; upper bits read 0. A write with value <2 stores 2.
  - Unmapped addresses read 0 and ignore writes.
- Reset values (while reset=0 at the edge):
  - tx=1, FIFO empty, overflow=0, BAUD_DIV=CLKS_PER_BIT, FSM=IDLE, bit and baud counters 0.
  - rdata=0 and irq=1 after reset.
- Reset mid-frame aborts the frame: tx returns high on that edge and queued bytes are discarded.
- FIFO:
  - Push when we and addr==0x0.
  - If full and no pop in the same cycle, the byte is dropped and overflow is set.
  - A simultaneous push and pop when full accepts the push.
  - Pointers wrap modulo FIFO_DEPTH; the count is held in log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register, go to START, and load the baud counter with BAUD_DIV-1.
  - START: tx=0 for BAUD_DIV cycles, then DATA with bit index 0.
  - DATA: tx=shift[bit index], LSB first. Each bit lasts BAUD_DIV cycles. After bit 7, go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles, then IDLE. A pending byte is popped on the first IDLE cycle, so the inter-frame gap is 1 cycle of idle high.
- Latency:
  - A TXDATA write at edge N with the FSM idle and the FIFO empty makes the FIFO non-empty after N.
  - The pop and START entry happen at edge N+1; tx falls after N+1.
  - A frame occupies exactly 10×BAUD_DIV cycles.
- BAUD_DIV writes mid-frame take effect at the next bit-counter reload.
- A write-1 to clear overflow in the same cycle as a new overflow leaves overflow=1.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - register offset constants TXDATA_OFS=0x0, STATUS_OFS=0x4, BAUD_OFS=0x8;
  - STATUS bit-index constants.
- One sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count), instantiated with width 8.
- Address decode, registers and serializer FSM live in uart_tx_mmio.

Test Plan:
- Write BAUD_DIV=4, then TXDATA=0x55 → tx, sampled every 4 cycles from the fall, is 0,1,0,1,0,1,0,1,0,1. The frame is 40 cycles; busy=1 throughout and irq=0.
- Write BAUD_DIV=1 → read back 2. Write 0xFFFF → read back 0xFFFF (bits 31:16 read 0).
- With BAUD_DIV=2, issue 10 TXDATA writes on consecutive cycles (0x00..0x09) → overflow=1 and bytes 0x00–0x08 are transmitted in order; 0x09 is never sent.
- Write STATUS bit3=1 after the overflow test → overflow=0, and other STATUS bits are unchanged.
- With BAUD_DIV=4, assert reset=0 for one cycle during DATA bit 3 of 0xA3 → tx=1 on the next cycle, fifo_empty=1, BAUD_DIV reads 868, and no further tx edges occur.
- Send two bytes 0x0F, 0xF0 back-to-back with BAUD_DIV=3 → the STOP of the first frame is followed by exactly 1 idle-high cycle before the second start bit. irq rises only after the second STOP completes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: serializer
// states, register offsets, STATUS bit positions and the divisor clamp.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Peripheral-local byte offsets of the registers
    localparam int unsigned TXDATA_OFS = 32'd0;
    localparam int unsigned STATUS_OFS = 32'd4;
    localparam int unsigned BAUD_OFS   = 32'd8;

    // STATUS register bit positions
    localparam int unsigned STAT_BUSY_BIT  = 32'd0;
    localparam int unsigned STAT_FULL_BIT  = 32'd1;
    localparam int unsigned STAT_EMPTY_BIT = 32'd2;
    localparam int unsigned STAT_OVF_BIT   = 32'd3;

    // Smallest divisor the serializer can run with
    localparam logic [15:0] BAUD_MIN = 16'd2;

    // Divisors below the minimum are stored as the minimum
    function automatic logic [15:0] clamp_baud(input logic [15:0] value);
        logic [15:0] result;
        if (value < BAUD_MIN) begin
            result = BAUD_MIN;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with show-ahead read data. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == CNT_W'(0));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA queue bytes in a
// FIFO; the serializer drains it at the programmed baud divisor. STATUS
// lets firmware poll for space and completion.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic              tx,
    output logic              irq
);

    localparam int          CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RST = 16'(CLKS_PER_BIT);

    // Register state
    logic [15:0]  r_baud;
    logic         r_ovf;

    // Serializer state
    uart_state_e  r_state;
    logic [15:0]  r_baud_cnt;
    logic [2:0]   r_bit_idx;
    logic [7:0]   r_shift;
    logic         r_tx;

    // Serializer next-state values
    uart_state_e  w_state_nxt;
    logic [15:0]  w_baud_cnt_nxt;
    logic [2:0]   w_bit_idx_nxt;
    logic [7:0]   w_shift_nxt;
    logic         w_tx_nxt;

    // Decode and FIFO handshake
    logic         w_sel_tx;
    logic         w_sel_stat;
    logic         w_sel_baud;
    logic         w_push;
    logic         w_pop;
    logic         w_ovf_set;
    logic         w_ovf_clr;
    logic         w_cnt_done;
    logic [15:0]  w_reload;
    logic [2:0]   w_bit_inc;
    logic [7:0]   w_fifo_rdata;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic         w_unused_wdata;

    assign w_sel_tx   = (addr == ADDR_W'(TXDATA_OFS));
    assign w_sel_stat = (addr == ADDR_W'(STATUS_OFS));
    assign w_sel_baud = (addr == ADDR_W'(BAUD_OFS));

    assign w_push     = we & w_sel_tx;
    assign w_pop      = (r_state == IDLE) & ~w_fifo_empty;
    assign w_ovf_set  = w_push & w_fifo_full & ~w_pop;
    assign w_ovf_clr  = we & w_sel_stat & wdata[STAT_OVF_BIT];

    assign w_cnt_done = (r_baud_cnt == 16'd0);
    assign w_reload   = r_baud - 16'd1;
    assign w_bit_inc  = r_bit_idx + 3'd1;

    // Upper store bits have no destination in this peripheral
    assign w_unused_wdata = &{1'b0, wdata[31:16]};

    assign tx  = r_tx;
    assign irq = (r_state == IDLE) & (w_fifo_count == CNT_W'(0));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (wdata[7:0]),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Baud divisor and sticky overflow; a new overflow beats a clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_baud <= BAUD_RST;
            r_ovf  <= 1'b0;
        end else begin
            if (we && w_sel_baud) begin
                r_baud <= clamp_baud(wdata[15:0]);
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serializer next-state and datapath; tx is computed one edge ahead
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_fifo_empty) begin
                    w_state_nxt    = START;
                    w_shift_nxt    = w_fifo_rdata;
                    w_baud_cnt_nxt = w_reload;
                    w_tx_nxt       = 1'b0;
                end else begin
                    w_baud_cnt_nxt = 16'd0;
                end
            end
            START: begin
                if (w_cnt_done) begin
                    w_state_nxt    = DATA;
                    w_baud_cnt_nxt = w_reload;
                    w_bit_idx_nxt  = 3'd0;
                    w_tx_nxt       = r_shift[0];
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt - 16'd1;
                end
            end
            DATA: begin
                if (w_cnt_done) begin
                    w_baud_cnt_nxt = w_reload;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt   = STOP;
                        w_bit_idx_nxt = 3'd0;
                        w_tx_nxt      = 1'b1;
                    end else begin
                        w_bit_idx_nxt = w_bit_inc;
                        w_tx_nxt      = r_shift[w_bit_inc];
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt - 16'd1;
                end
            end
            STOP: begin
                if (w_cnt_done) begin
                    w_state_nxt    = IDLE;
                    w_baud_cnt_nxt = 16'd0;
                    w_tx_nxt       = 1'b1;
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_baud_cnt_nxt = 16'd0;
                w_bit_idx_nxt  = 3'd0;
                w_tx_nxt       = 1'b1;
            end
        endcase
    end

    // Serializer state register; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // Load data path; zero whenever no load is in progress
    always_comb begin
        rdata = 32'd0;
        if (re) begin
            if (w_sel_stat) begin
                rdata[STAT_BUSY_BIT]  = (r_state != IDLE);
                rdata[STAT_FULL_BIT]  = w_fifo_full;
                rdata[STAT_EMPTY_BIT] = w_fifo_empty;
                rdata[STAT_OVF_BIT]   = r_ovf;
            end else if (w_sel_baud) begin
                rdata = {16'd0, r_baud};
            end else begin
                rdata = 32'd0;
            end
        end else begin
            rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a background receiver decodes tx
// frames into a queue that is checked against bytes expected at write time.
module tb_uart_tx_mmio;

    logic        clk;
    logic        reset;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int tests_run;
    int tests_failed;

    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    int         mon_div;
    bit         mon_en;

    logic [7:0] mon_bits;
    logic       mon_stop;
    int         mon_d;

    uart_tx_mmio #(
        .CLKS_PER_BIT (868),
        .FIFO_DEPTH   (8),
        .ADDR_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .re    (re),
        .rdata (rdata),
        .tx    (tx),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Background receiver: start detected half a cycle in, then one sample per bit
    always begin
        @(negedge clk);
        if (mon_en && reset === 1'b1 && tx === 1'b0) begin
            mon_d = mon_div;
            for (int k = 0; k < 8; k++) begin
                repeat (mon_d) @(negedge clk);
                mon_bits[k] = tx;
            end
            repeat (mon_d) @(negedge clk);
            mon_stop = tx;
            rx_q.push_back({mon_stop, mon_bits});
        end
    end

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
        addr = a;
        re   = 1'b1;
        #1;
        d    = rdata;
        re   = 1'b0;
    endtask

    task automatic set_baud(input logic [31:0] v);
        write_reg(4'h8, v);
        mon_div = (v[15:0] < 16'd2) ? 2 : int'(v[15:0]);
    endtask

    task automatic wait_fall(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_irq(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (irq === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pins: tx=%b irq=%b expected tx=1 irq=1", tx, irq);
        end
        tests_run++;
        if (rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        read_reg(4'h4, d);
        tests_run++;
        if (d !== 32'h4) begin
            tests_failed++;
            $display("FAIL reset_status: got %h expected 00000004", d);
        end
        read_reg(4'h8, d);
        tests_run++;
        if (d !== 32'd868) begin
            tests_failed++;
            $display("FAIL reset_baud: got %0d expected 868", d);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        set_baud(32'd1);
        read_reg(4'h8, d);
        tests_run++;
        if (d !== 32'd2) begin
            tests_failed++;
            $display("FAIL baud_clamp1: got %h expected 2", d);
        end
        set_baud(32'd0);
        read_reg(4'h8, d);
        tests_run++;
        if (d !== 32'd2) begin
            tests_failed++;
            $display("FAIL baud_clamp0: got %h expected 2", d);
        end
        set_baud(32'hFFFF);
        read_reg(4'h8, d);
        tests_run++;
        if (d !== 32'h0000FFFF) begin
            tests_failed++;
            $display("FAIL baud_ffff: got %h expected 0000ffff", d);
        end
        set_baud(32'h12345678);
        read_reg(4'h8, d);
        tests_run++;
        if (d !== 32'h00005678) begin
            tests_failed++;
            $display("FAIL baud_upper: got %h expected 00005678", d);
        end
        write_reg(4'hC, 32'hFFFFFFFF);
        read_reg(4'hC, d);
        tests_run++;
        if (d !== 32'd0) begin
            tests_failed++;
            $display("FAIL unmapped_read: got %h expected 0", d);
        end
        read_reg(4'h8, d);
        tests_run++;
        if (d !== 32'h00005678) begin
            tests_failed++;
            $display("FAIL unmapped_write: baud got %h expected 00005678", d);
        end
        read_reg(4'h0, d);
        tests_run++;
        if (d !== 32'd0) begin
            tests_failed++;
            $display("FAIL txdata_read: got %h expected 0", d);
        end
    endtask

    task automatic test_frame_55();
        logic [31:0] d;
        logic [9:0]  frame;
        bit          ok;
        bit          bad_tx;
        bit          bad_stat;
        logic [8:0]  e;
        logic [8:0]  r;
        frame = {1'b1, 8'h55, 1'b0};
        set_baud(32'd4);
        write_reg(4'h0, 32'h55);
        exp_q.push_back({1'b1, 8'h55});
        wait_fall(20, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL frame55_start: tx=%b expected fall within 20 cycles", tx);
            return;
        end
        bad_tx   = 1'b0;
        bad_stat = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx !== frame[i/4]) begin
                bad_tx = 1'b1;
                $display("FAIL frame55_bit: cycle %0d tx=%b expected %b", i, tx, frame[i/4]);
            end
            read_reg(4'h4, d);
            if (d[0] !== 1'b1 || irq !== 1'b0) begin
                bad_stat = 1'b1;
                $display("FAIL frame55_busy: cycle %0d busy=%b irq=%b expected busy=1 irq=0", i, d[0], irq);
            end
            @(negedge clk);
        end
        tests_run++;
        if (bad_tx) tests_failed++;
        tests_run++;
        if (bad_stat) tests_failed++;
        read_reg(4'h4, d);
        tests_run++;
        if (d[0] !== 1'b0 || irq !== 1'b1 || tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame55_end: busy=%b irq=%b tx=%b expected 0 1 1", d[0], irq, tx);
        end
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (rx_q.size() == 0) begin
                tests_failed++;
                $display("FAIL frame55_rx: got nothing expected %h", e);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    tests_failed++;
                    $display("FAIL frame55_rx: got %h expected %h", r, e);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        bit          ok;
        logic [8:0]  e;
        logic [8:0]  r;
        set_baud(32'd2);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            addr  = 4'h0;
            wdata = 32'(i);
            we    = 1'b1;
            // one byte leaves at once for the serializer, the FIFO holds the rest
            if (i < 8 + 1) exp_q.push_back({1'b1, 8'(i)});
            @(negedge clk);
        end
        we = 1'b0;
        read_reg(4'h4, d);
        tests_run++;
        if (d !== 32'h0000000B) begin
            tests_failed++;
            $display("FAIL ovf_status: got %h expected 0000000b", d);
        end
        wait_irq(3000, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL ovf_drain: irq=%b expected 1 within 3000 cycles", irq);
        end
        repeat (5) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (rx_q.size() == 0) begin
                tests_failed++;
                $display("FAIL ovf_rx: got nothing expected %h", e);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    tests_failed++;
                    $display("FAIL ovf_rx: got %h expected %h", r, e);
                end
            end
        end
        repeat (40) @(negedge clk);
        tests_run++;
        if (rx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL ovf_extra: got %0d extra frames expected 0", rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic test_clear_overflow();
        logic [31:0] d;
        write_reg(4'h4, 32'h7);
        read_reg(4'h4, d);
        tests_run++;
        if (d !== 32'h0000000C) begin
            tests_failed++;
            $display("FAIL ovf_noclear: got %h expected 0000000c", d);
        end
        write_reg(4'h4, 32'h8);
        read_reg(4'h4, d);
        tests_run++;
        if (d !== 32'h00000004) begin
            tests_failed++;
            $display("FAIL ovf_clear: got %h expected 00000004", d);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        bit          ok;
        bit          moved;
        mon_en = 1'b0;
        set_baud(32'd4);
        @(negedge clk);
        addr  = 4'h0;
        wdata = 32'hA3;
        we    = 1'b1;
        @(negedge clk);
        wdata = 32'h5A;
        @(negedge clk);
        we    = 1'b0;
        wait_fall(20, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rstmid_start: tx=%b expected fall within 20 cycles", tx);
            mon_en = 1'b1;
            return;
        end
        repeat (17) @(negedge clk);
        tests_run++;
        if (tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_bit3: tx=%b expected 0", tx);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tests_run++;
        if (tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_tx: tx=%b expected 1", tx);
        end
        read_reg(4'h4, d);
        tests_run++;
        if (d !== 32'h00000004) begin
            tests_failed++;
            $display("FAIL rstmid_status: got %h expected 00000004", d);
        end
        read_reg(4'h8, d);
        tests_run++;
        if (d !== 32'd868) begin
            tests_failed++;
            $display("FAIL rstmid_baud: got %0d expected 868", d);
        end
        moved = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) moved = 1'b1;
        end
        tests_run++;
        if (moved) begin
            tests_failed++;
            $display("FAIL rstmid_quiet: tx moved expected steady 1");
        end
        mon_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit          ok;
        bit          bad_irq;
        logic [8:0]  e;
        logic [8:0]  r;
        set_baud(32'd3);
        @(negedge clk);
        addr  = 4'h0;
        wdata = 32'h0F;
        we    = 1'b1;
        exp_q.push_back({1'b1, 8'h0F});
        @(negedge clk);
        wdata = 32'hF0;
        exp_q.push_back({1'b1, 8'hF0});
        @(negedge clk);
        we    = 1'b0;
        wait_fall(20, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL b2b_start: tx=%b expected fall within 20 cycles", tx);
            return;
        end
        bad_irq = 1'b0;
        for (int j = 0; j < 62; j++) begin
            if (j == 30) begin
                tests_run++;
                if (tx !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_gap: tx=%b expected 1", tx);
                end
            end
            if (j == 31) begin
                tests_run++;
                if (tx !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_start2: tx=%b expected 0", tx);
                end
            end
            if (irq !== (j >= 61)) begin
                bad_irq = 1'b1;
                $display("FAIL b2b_irq: cycle %0d irq=%b expected %b", j, irq, (j >= 61));
            end
            @(negedge clk);
        end
        tests_run++;
        if (bad_irq) tests_failed++;
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (rx_q.size() == 0) begin
                tests_failed++;
                $display("FAIL b2b_rx: got nothing expected %h", e);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    tests_failed++;
                    $display("FAIL b2b_rx: got %h expected %h", r, e);
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b0;
        addr    = 4'h0;
        wdata   = 32'd0;
        we      = 1'b0;
        re      = 1'b0;
        mon_div = 868;
        mon_en  = 1'b1;
        @(negedge clk);
        test_reset();
        test_regs();
        test_frame_55();
        test_overflow();
        test_clear_overflow();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
